// File: rtl/poly_addsub_lanes.sv
// Multi-lane modular add/subtract for polynomial coefficients, 2-stage valid/ready pipeline.
// Each beat carries its own op and modulus select; the final beat of every polynomial is tagged out_last.
module poly_addsub_lanes #(
   parameter int          LANES = 2,
   parameter int          W     = 25,
   parameter int unsigned Q0    = 33292289,
   parameter int unsigned Q1    = 16515073,
   parameter int          BEATS = 128
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               op,
   input  logic               q_mod,
   input  logic [LANES*W-1:0] din1,
   input  logic [LANES*W-1:0] din2,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [LANES*W-1:0] dout,
   output logic               out_last
);

   localparam logic [W-1:0] LP_Q0   = W'(Q0);
   localparam logic [W-1:0] LP_Q1   = W'(Q1);
   localparam logic [15:0]  LP_LAST = 16'(BEATS - 1);

   logic                      w_en;
   logic                      w_inXfer;
   logic                      w_isLast;
   logic [LANES-1:0][W:0]     w_s1Next;
   logic [LANES*W-1:0]        w_s2Next;

   logic                      r_s1Valid;
   logic                      r_s1Op;
   logic                      r_s1Last;
   logic [W-1:0]              r_s1Q;
   logic [LANES-1:0][W:0]     r_s1Sum;
   logic [15:0]               r_beatCnt;
   logic                      r_outValid;
   logic                      r_outLast;
   logic [LANES*W-1:0]        r_dout;

   // The whole pipeline advances together whenever the output slot is empty or being drained.
   assign w_en     = !r_outValid || out_ready;
   assign w_inXfer = in_valid && w_en;
   assign w_isLast = (r_beatCnt == LP_LAST);
   assign in_ready = w_en;

   // Conditional correction: add wraps down when s >= q, subtract wraps up when s went negative.
   function automatic logic [W-1:0] reduceLane(input logic [W:0] s, input logic isSub,
                                               input logic [W-1:0] q);
      logic [W:0] res;
      res = s;
      if (!isSub) begin
         if (s >= {1'b0, q})
            res = s - {1'b0, q};
      end else if (s[W]) begin
         res = s + {1'b0, q};
      end
      return res[W-1:0];
   endfunction

   always_comb begin
      w_s1Next = '0;
      w_s2Next = '0;
      for (int i = 0; i < LANES; i++) begin
         if (op)
            w_s1Next[i] = {1'b0, din1[i*W +: W]} - {1'b0, din2[i*W +: W]};
         else
            w_s1Next[i] = {1'b0, din1[i*W +: W]} + {1'b0, din2[i*W +: W]};
         if (r_s1Valid)
            w_s2Next[i*W +: W] = reduceLane(r_s1Sum[i], r_s1Op, r_s1Q);
      end
   end

   // Both stages; a missing input beat enters as an all-zero bubble so dout reads 0 behind it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1Valid  <= 1'b0;
         r_s1Op     <= 1'b0;
         r_s1Last   <= 1'b0;
         r_s1Q      <= '0;
         r_s1Sum    <= '0;
         r_outValid <= 1'b0;
         r_outLast  <= 1'b0;
         r_dout     <= '0;
      end else if (w_en) begin
         r_s1Valid  <= w_inXfer;
         r_s1Op     <= w_inXfer && op;
         r_s1Last   <= w_inXfer && w_isLast;
         r_s1Q      <= w_inXfer ? (q_mod ? LP_Q1 : LP_Q0) : '0;
         r_s1Sum    <= w_inXfer ? w_s1Next : '0;
         r_outValid <= r_s1Valid;
         r_outLast  <= r_s1Valid && r_s1Last;
         r_dout     <= w_s2Next;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_beatCnt <= '0;
      else if (w_inXfer)
         r_beatCnt <= w_isLast ? 16'd0 : r_beatCnt + 16'd1;
   end

   assign out_valid = r_outValid;
   assign out_last  = r_outLast;
   assign dout      = r_dout;

endmodule

// File: tb/tb_poly_addsub_lanes.sv
// Bench for poly_addsub_lanes (BEATS=4): directed table, hand-written stall/reset/last sequences,
// and a random phase checked by a scoreboard against an independent (a +/- b) mod q model.
module tb_poly_addsub_lanes;

   localparam int          W     = 25;
   localparam int          LANES = 2;
   localparam int unsigned Q0    = 33292289;
   localparam int unsigned Q1    = 16515073;
   localparam int          BEATS = 4;

   logic               clk = 1'b0;
   logic               rst;
   logic               in_valid;
   logic               in_ready;
   logic               op;
   logic               q_mod;
   logic [LANES*W-1:0] din1;
   logic [LANES*W-1:0] din2;
   logic               out_valid;
   logic               out_ready;
   logic [LANES*W-1:0] dout;
   logic               out_last;

   int total = 0;
   int bad   = 0;
   int inCount = 0;
   int modelCnt = 0;
   logic [LANES*W:0] expQ[$];
   logic [W-1:0]     seenLane0[$];
   bit               seenLast[$];

   typedef struct {
      bit           op;
      bit           qm;
      logic [W-1:0] a0, b0, a1, b1, e0, e1;
   } vec_t;
   vec_t vecs[6];

   poly_addsub_lanes #(.LANES(LANES), .W(W), .Q0(Q0), .Q1(Q1), .BEATS(BEATS)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op), .q_mod(q_mod),
      .din1(din1), .din2(din2), .out_valid(out_valid), .out_ready(out_ready), .dout(dout),
      .out_last(out_last)
   );

   always #5 clk = ~clk;

   function automatic logic [W-1:0] refMod(input bit isSub, input bit qm,
                                           input logic [W-1:0] a, input logic [W-1:0] b);
      longint q = qm ? longint'(Q1) : longint'(Q0);
      longint r;
      if (isSub) r = (longint'(a) + q - longint'(b)) % q;
      else       r = (longint'(a) + longint'(b)) % q;
      return W'(r);
   endfunction

   task automatic check(input string name, input longint act, input longint req);
      total++;
      if (act != req) begin
         bad++;
         $display("[TB] FAIL %s: got %0d, want %0d", name, act, req);
      end
   endtask

   // Scoreboard: transfers are decided at the next rising edge, so inputs/outputs are sampled here.
   always @(negedge clk) begin
      logic [LANES*W:0] e;
      bit lastFlag;
      if (rst) begin
         expQ.delete();
         modelCnt = 0;
      end else begin
         if (out_valid && out_ready) begin
            total++;
            if (expQ.size() == 0) begin
               bad++;
               $display("[TB] FAIL unexpected_output: got dout=%h, want no beat", dout);
            end else begin
               e = expQ.pop_front();
               if ({dout, out_last} !== e) begin
                  bad++;
                  $display("[TB] FAIL scoreboard: got %h last=%0b, want %h last=%0b",
                           dout, out_last, e[LANES*W:1], e[0]);
               end
            end
            seenLane0.push_back(dout[W-1:0]);
            seenLast.push_back(out_last);
         end
         if (!out_valid) check("last_without_valid", out_last, 0);
         if (in_valid && in_ready) begin
            lastFlag = (modelCnt == BEATS - 1);
            modelCnt = lastFlag ? 0 : modelCnt + 1;
            expQ.push_back({refMod(op, q_mod, din1[2*W-1:W], din2[2*W-1:W]),
                            refMod(op, q_mod, din1[W-1:0], din2[W-1:0]), lastFlag});
            inCount++;
         end
      end
   end

   // Caller is always just after a rising edge; returns just after the edge that took the beat.
   task automatic applyStimulus(input bit opI, input bit qmI, input logic [W-1:0] a0,
                                input logic [W-1:0] b0, input logic [W-1:0] a1,
                                input logic [W-1:0] b1);
      bit taken = 0;
      op = opI; q_mod = qmI; din1 = {a1, a0}; din2 = {b1, b0}; in_valid = 1'b1;
      for (int t = 0; t < 100 && !taken; t++) begin
         @(negedge clk);
         if (in_ready) taken = 1;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      if (!taken) check("accept_timeout", 0, 1);
   endtask

   task automatic drain();
      out_ready = 1'b1;
      for (int t = 0; t < 200 && expQ.size() != 0; t++) @(negedge clk);
      check("drain_pending", expQ.size(), 0);
      @(posedge clk); #1;
   endtask

   task automatic pulseReset();
      rst = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   initial begin
      logic [W-1:0] ra, rb, ra1, rb1;
      int cycles;
      int startIn;
      vecs[0] = '{0, 0, 33292288, 1, 5, 6, 0, 11};
      vecs[1] = '{1, 0, 0, 1, 100, 40, 33292288, 60};
      vecs[2] = '{1, 1, 5, 7, 16515072, 16515072, 16515071, 0};
      vecs[3] = '{0, 1, 16515072, 16515072, 0, 0, 16515071, 0};
      vecs[4] = '{0, 0, 20000000, 13292289, 20000000, 13292288, 0, 33292288};
      vecs[5] = '{1, 0, 33292288, 0, 0, 33292288, 33292288, 1};

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; op = 1'b0; q_mod = 1'b0;
      din1 = '0; din2 = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_out_valid", out_valid, 0);
      check("reset_out_last", out_last, 0);
      check("reset_dout", dout, 0);
      check("reset_in_ready", in_ready, 1);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      // Directed table: exact latency, result, then the trailing bubble reads zero.
      for (int i = 0; i < 6; i++) begin
         applyStimulus(vecs[i].op, vecs[i].qm, vecs[i].a0, vecs[i].b0, vecs[i].a1, vecs[i].b1);
         @(negedge clk);
         check($sformatf("v%0d_early_valid", i), out_valid, 0);
         @(negedge clk);
         check($sformatf("v%0d_valid", i), out_valid, 1);
         check($sformatf("v%0d_lane0", i), dout[W-1:0], vecs[i].e0);
         check($sformatf("v%0d_lane1", i), dout[2*W-1:W], vecs[i].e1);
         @(negedge clk);
         check($sformatf("v%0d_bubble_valid", i), out_valid, 0);
         check($sformatf("v%0d_bubble_dout", i), dout, 0);
         @(posedge clk); #1;
      end

      // Alternating modulus back-to-back: each beat keeps its own q.
      pulseReset();
      seenLane0.delete();
      for (int i = 0; i < 4; i++) applyStimulus(1, i[0], 0, 1, 3, 5);
      drain();
      check("alt_count", seenLane0.size(), 4);
      if (seenLane0.size() == 4) begin
         check("alt_b0", seenLane0[0], 33292288);
         check("alt_b1", seenLane0[1], 16515072);
         check("alt_b2", seenLane0[2], 33292288);
         check("alt_b3", seenLane0[3], 16515072);
      end

      // Backpressure: stall 3 cycles once the first result is visible.
      pulseReset();
      seenLane0.delete();
      applyStimulus(0, 0, 10, 0, 0, 0);
      applyStimulus(0, 0, 11, 1, 0, 0);
      out_ready = 1'b0;
      op = 1'b0; q_mod = 1'b0; din1 = {25'd0, 25'd12}; din2 = {25'd0, 25'd2}; in_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check($sformatf("stall%0d_valid", k), out_valid, 1);
         check($sformatf("stall%0d_dout", k), dout[W-1:0], 10);
         check($sformatf("stall%0d_in_ready", k), in_ready, 0);
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      applyStimulus(0, 0, 12, 2, 0, 0);
      applyStimulus(0, 0, 13, 3, 0, 0);
      drain();
      check("bp_count", seenLane0.size(), 4);
      for (int i = 0; i < 4 && i < seenLane0.size(); i++)
         check($sformatf("bp_order%0d", i), seenLane0[i], 10 + 2 * i);

      // Nine consecutive beats: last on the 4th and 8th only.
      pulseReset();
      seenLast.delete();
      for (int i = 0; i < 9; i++) applyStimulus(0, 1, W'(i), 1, 0, 0);
      drain();
      check("last9_count", seenLast.size(), 9);
      for (int i = 0; i < 9 && i < seenLast.size(); i++)
         check($sformatf("last9_b%0d", i), seenLast[i], (i == 3 || i == 7) ? 1 : 0);

      // Reset with beats in flight clears the output and restarts the polynomial.
      pulseReset();
      applyStimulus(0, 0, 7, 8, 9, 10);
      applyStimulus(0, 0, 7, 8, 9, 10);
      rst = 1'b1;
      #1;
      check("rst_mid_valid", out_valid, 0);
      check("rst_mid_dout", dout, 0);
      check("rst_mid_in_ready", in_ready, 1);
      @(posedge clk); #1;
      rst = 1'b0;
      seenLast.delete();
      for (int i = 0; i < 4; i++) applyStimulus(1, 0, 50, W'(i), 0, 0);
      drain();
      check("rst_last_count", seenLast.size(), 4);
      for (int i = 0; i < 4 && i < seenLast.size(); i++)
         check($sformatf("rst_last_b%0d", i), seenLast[i], (i == 3) ? 1 : 0);

      // Random traffic with random valid/ready.
      startIn = inCount;
      cycles = 0;
      while (inCount < startIn + 10000 && cycles < 60000) begin
         q_mod = $urandom_range(1, 0);
         op = $urandom_range(1, 0);
         ra  = W'($urandom_range((q_mod ? Q1 : Q0) - 1, 0));
         rb  = W'($urandom_range((q_mod ? Q1 : Q0) - 1, 0));
         ra1 = W'($urandom_range((q_mod ? Q1 : Q0) - 1, 0));
         rb1 = W'($urandom_range((q_mod ? Q1 : Q0) - 1, 0));
         din1 = {ra1, ra}; din2 = {rb1, rb};
         in_valid  = ($urandom_range(3, 0) != 0);
         out_ready = ($urandom_range(3, 0) != 0);
         @(posedge clk); #1;
         cycles++;
      end
      in_valid = 1'b0;
      check("random_beats", inCount - startIn, 10000);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
